// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among several LSUs.
// One request is in flight at a time; the response is held until the LSU drops its valid.
module lsu_mem_arbiter #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int unsigned PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [PTR_BITS-1:0] LAST_ID = PTR_BITS'(NUM_CONSUMERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        RELAYING
    } state_t;

    state_t                           state, state_d;
    logic [PTR_BITS-1:0]              rr_ptr, rr_ptr_d;
    logic [PTR_BITS-1:0]              grant_id, grant_id_d;
    logic [PTR_BITS-1:0]              sel;
    logic [31:0]                      cand;
    logic                             found;
    logic                             served_valid;

    logic                             mem_read_valid_d;
    logic [ADDR_BITS-1:0]             mem_read_address_d;
    logic                             mem_write_valid_d;
    logic [ADDR_BITS-1:0]             mem_write_address_d;
    logic [DATA_BITS-1:0]             mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]         consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0]         consumer_write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_d;

    // State and all outputs are registered together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            grant_id             <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
        end else begin
            state                <= state_d;
            rr_ptr               <= rr_ptr_d;
            grant_id             <= grant_id_d;
            mem_read_valid       <= mem_read_valid_d;
            mem_read_address     <= mem_read_address_d;
            mem_write_valid      <= mem_write_valid_d;
            mem_write_address    <= mem_write_address_d;
            mem_write_data       <= mem_write_data_d;
            consumer_read_ready  <= consumer_read_ready_d;
            consumer_write_ready <= consumer_write_ready_d;
            consumer_read_data   <= consumer_read_data_d;
        end
    end

    always_comb begin
        state_d                = state;
        rr_ptr_d               = rr_ptr;
        grant_id_d             = grant_id;
        mem_read_valid_d       = mem_read_valid;
        mem_read_address_d     = mem_read_address;
        mem_write_valid_d      = mem_write_valid;
        mem_write_address_d    = mem_write_address;
        mem_write_data_d       = mem_write_data;
        consumer_read_ready_d  = consumer_read_ready;
        consumer_write_ready_d = consumer_write_ready;
        consumer_read_data_d   = consumer_read_data;
        sel                    = '0;
        cand                   = '0;
        found                  = 1'b0;
        served_valid           = 1'b0;

        unique case (state)
            IDLE: begin
                // First requester at or after rr_ptr, wrapping, wins.
                for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                    cand = 32'(rr_ptr) + k;
                    if (cand >= NUM_CONSUMERS) begin
                        cand = cand - NUM_CONSUMERS;
                    end
                    if (!found && (consumer_read_valid[PTR_BITS'(cand)]
                                   || consumer_write_valid[PTR_BITS'(cand)])) begin
                        found = 1'b1;
                        sel   = PTR_BITS'(cand);
                    end
                end
                if (found) begin
                    grant_id_d = sel;
                    if (consumer_read_valid[sel]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[32'(sel)*ADDR_BITS +: ADDR_BITS];
                        state_d            = READ_WAITING;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[32'(sel)*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = consumer_write_data[32'(sel)*DATA_BITS +: DATA_BITS];
                        state_d             = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    consumer_read_data_d[32'(grant_id)*DATA_BITS +: DATA_BITS] = mem_read_data;
                    consumer_read_ready_d[grant_id] = 1'b1;
                    mem_read_valid_d                = 1'b0;
                    state_d                         = RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    consumer_write_ready_d[grant_id] = 1'b1;
                    mem_write_valid_d                = 1'b0;
                    state_d                          = RELAYING;
                end
            end
            RELAYING: begin
                // The raised ready bit tells which valid this grant served.
                served_valid = consumer_read_ready[grant_id] ? consumer_read_valid[grant_id]
                                                             : consumer_write_valid[grant_id];
                if (!served_valid) begin
                    consumer_read_ready_d[grant_id]  = 1'b0;
                    consumer_write_ready_d[grant_id] = 1'b0;
                    rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + PTR_BITS'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: reset, single read/write, fairness, stall, reset mid-read.
module tb_lsu_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AB = 8;
    localparam int unsigned DB = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      crv;
    logic [N*AB-1:0]   cra;
    logic [N-1:0]      crr;
    logic [N*DB-1:0]   crd;
    logic [N-1:0]      cwv;
    logic [N*AB-1:0]   cwa;
    logic [N*DB-1:0]   cwd;
    logic [N-1:0]      cwr;
    logic              mrv;
    logic [AB-1:0]     mra;
    logic              mrr;
    logic [DB-1:0]     mrd;
    logic              mwv;
    logic [AB-1:0]     mwa;
    logic [DB-1:0]     mwd;
    logic              mwr;

    int checks = 0;
    int errors = 0;
    int e;

    lsu_mem_arbiter #(
        .NUM_CONSUMERS(N),
        .ADDR_BITS(AB),
        .DATA_BITS(DB)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (cra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwa),
        .consumer_write_data    (cwd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held with every consumer requesting.
        reset = 1'b0;
        crv = 4'hF; cwv = 4'hF;
        cra = 32'h13121110; cwa = 32'hA3A2A1A0; cwd = 32'hB3B2B1B0;
        mrr = 1'b0; mrd = 8'h00; mwr = 1'b0;
        tick(); tick();
        check("rst_crr", 64'(crr), 64'h0);
        check("rst_cwr", 64'(cwr), 64'h0);
        check("rst_crd", 64'(crd), 64'h0);
        check("rst_mrv", 64'(mrv), 64'h0);
        check("rst_mwv", 64'(mwv), 64'h0);
        check("rst_mra", 64'(mra), 64'h0);
        check("rst_mwa", 64'(mwa), 64'h0);
        check("rst_mwd", 64'(mwd), 64'h0);

        // First grant after release goes to consumer 0.
        reset = 1'b1; cwv = 4'h0;
        tick();
        check("first_mrv", 64'(mrv), 64'h1);
        check("first_mra", 64'(mra), 64'h10);
        check("first_mwv", 64'(mwv), 64'h0);
        mrr = 1'b1; mrd = 8'hA0;
        tick();
        check("first_crr", 64'(crr), 64'h1);
        check("first_crd", 64'(crd), 64'h000000A0);
        check("first_mrv_clr", 64'(mrv), 64'h0);
        mrr = 1'b0; crv = 4'h0;
        tick();
        check("first_release", 64'(crr), 64'h0);

        // Single read from consumer 2; memory ready in RELAYING must be ignored.
        crv = 4'b0100; cra[2*AB +: AB] = 8'h1A;
        tick();
        check("rd_mrv", 64'(mrv), 64'h1);
        check("rd_mra", 64'(mra), 64'h1A);
        check("rd_crr_early", 64'(crr), 64'h0);
        mrr = 1'b1; mrd = 8'h5C;
        tick();
        check("rd_crr", 64'(crr), 64'h4);
        check("rd_crd", 64'(crd), 64'h005C00A0);
        mrd = 8'h99;
        tick();
        check("rd_hold_crr", 64'(crr), 64'h4);
        check("rd_hold_crd", 64'(crd), 64'h005C00A0);
        mrr = 1'b0; crv = 4'h0;
        tick();
        check("rd_release", 64'(crr), 64'h0);
        check("rd_mrv_idle", 64'(mrv), 64'h0);

        // Single write from consumer 1; bus changes after grant are ignored.
        cwv = 4'b0010; cwa[1*AB +: AB] = 8'h33; cwd[1*DB +: DB] = 8'h7E;
        tick();
        check("wr_mwv", 64'(mwv), 64'h1);
        check("wr_mwa", 64'(mwa), 64'h33);
        check("wr_mwd", 64'(mwd), 64'h7E);
        check("wr_mrv", 64'(mrv), 64'h0);
        cwa[1*AB +: AB] = 8'h44; cwd[1*DB +: DB] = 8'h11;
        tick();
        check("wr_hold_mwa", 64'(mwa), 64'h33);
        check("wr_hold_mwd", 64'(mwd), 64'h7E);
        check("wr_hold_cwr", 64'(cwr), 64'h0);
        mwr = 1'b1;
        tick();
        check("wr_cwr", 64'(cwr), 64'h2);
        check("wr_mwv_clr", 64'(mwv), 64'h0);
        check("wr_mrv_relay", 64'(mrv), 64'h0);
        check("wr_crr", 64'(crr), 64'h0);
        mwr = 1'b0; cwv = 4'h0;
        tick();
        check("wr_release", 64'(cwr), 64'h0);

        // Fairness from a fresh reset: grants 0,1,2,3,0,1.
        reset = 1'b0;
        tick();
        reset = 1'b1; crv = 4'hF; cra = 32'h23222120;
        for (int g = 0; g < 6; g++) begin
            e = g % 4;
            tick();
            check("fair_mrv", 64'(mrv), 64'h1);
            check("fair_mra", 64'(mra), 64'(32'h20 + e));
            check("fair_overlap", 64'(mrv & mwv), 64'h0);
            mrr = 1'b1; mrd = 8'(32'h60 + g);
            tick();
            check("fair_crr", 64'(crr), 64'(32'h1 << e));
            check("fair_crd", 64'(crd[e*DB +: DB]), 64'(32'h60 + g));
            mrr = 1'b0; crv[e] = 1'b0;
            tick();
            check("fair_release", 64'(crr), 64'h0);
            crv[e] = 1'b1;
        end
        crv = 4'h0;
        tick();

        // Memory stall on consumer 3 for 10 cycles.
        crv = 4'b1000; cra[3*AB +: AB] = 8'h77;
        tick();
        check("stall_grant_mra", 64'(mra), 64'h77);
        cra[3*AB +: AB] = 8'h88;
        for (int s = 0; s < 10; s++) begin
            tick();
            check("stall_mrv", 64'(mrv), 64'h1);
            check("stall_mra", 64'(mra), 64'h77);
            check("stall_crr", 64'(crr), 64'h0);
        end
        mrr = 1'b1; mrd = 8'h3C;
        tick();
        check("stall_crr_done", 64'(crr), 64'h8);
        check("stall_crd", 64'(crd[3*DB +: DB]), 64'h3C);
        mrr = 1'b0; crv = 4'h0;
        tick();
        check("stall_release", 64'(crr), 64'h0);

        // Pointer wrapped to 0; consumer 0 read beats its own write and consumer 3.
        crv = 4'b1001; cwv = 4'b0001;
        cra[0 +: AB] = 8'h40; cra[3*AB +: AB] = 8'h43;
        cwa[0 +: AB] = 8'h50; cwd[0 +: DB] = 8'h5A;
        tick();
        check("wrap_mrv", 64'(mrv), 64'h1);
        check("wrap_mra", 64'(mra), 64'h40);
        check("wrap_mwv", 64'(mwv), 64'h0);
        mrr = 1'b1; mrd = 8'hD0;
        tick();
        check("wrap_crr", 64'(crr), 64'h1);
        mrr = 1'b0; crv[0] = 1'b0;
        tick();
        check("wrap_release", 64'(crr), 64'h0);
        tick();
        check("next_mra", 64'(mra), 64'h43);
        check("next_mwv", 64'(mwv), 64'h0);

        // Reset in READ_WAITING while memory answers: no relay, restart from consumer 0.
        reset = 1'b0; mrr = 1'b1; mrd = 8'hFF;
        tick();
        check("mid_mrv", 64'(mrv), 64'h0);
        check("mid_crr", 64'(crr), 64'h0);
        check("mid_crd", 64'(crd), 64'h0);
        reset = 1'b1; mrr = 1'b0;
        tick();
        check("mid_regrant_mwv", 64'(mwv), 64'h1);
        check("mid_regrant_mwa", 64'(mwa), 64'h50);
        check("mid_regrant_mwd", 64'(mwd), 64'h5A);
        check("mid_regrant_mrv", 64'(mrv), 64'h0);
        check("mid_regrant_crr", 64'(crr), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
